// File: rtl/ysyx_23060240_imem_resp.sv
// Instruction-memory responder: one fetch outstanding, fixed LATENCY from accept to response.
// Optional access-fault checking is compiled in with `define IMEM_ERR_EN.
module ysyx_23060240_imem_resp #(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_inst_o,
`ifdef IMEM_ERR_EN
    output logic        resp_err_o,
`endif
    input  logic        ld_en_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] resp_inst_q;
    logic [31:0] mem [DEPTH];
    logic        enter_resp;
    logic        ld_ok;

    function automatic logic [AW-1:0] word_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return AW'(off >> 2);
    endfunction

`ifdef IMEM_ERR_EN
    logic resp_err_q;
    logic rd_fault;

    function automatic logic is_fault(input logic [31:0] a);
        logic [32:0] limit;
        logic [31:0] off;
        limit = 33'(DEPTH) << 2;
        off   = a - BASE;
        return (a[1:0] != 2'b00) || (a < BASE) || ({1'b0, off} >= limit);
    endfunction

    assign rd_fault   = is_fault(addr_q);
    assign ld_ok      = ld_en_i && !is_fault(ld_addr_i);
    assign resp_err_o = resp_err_q;
`else
    assign ld_ok = ld_en_i;
`endif

    // The counter is loaded with LATENCY-1 so resp_valid rises exactly LATENCY edges after accept.
    assign enter_resp  = (state_q == WAIT) && (cnt_q == 4'd0);
    assign resp_inst_o = resp_inst_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Registered read on the RESP-entry edge; a same-edge load therefore returns the old word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_inst_q <= 32'h0;
`ifdef IMEM_ERR_EN
            resp_err_q  <= 1'b0;
`endif
        end else if (enter_resp) begin
`ifdef IMEM_ERR_EN
            resp_err_q  <= rd_fault;
            resp_inst_q <= rd_fault ? 32'h0 : mem[word_index(addr_q)];
`else
            resp_inst_q <= mem[word_index(addr_q)];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (ld_ok) begin
            mem[word_index(ld_addr_i)] <= ld_data_i;
        end
    end
endmodule

// File: tb/tb_ysyx_23060240_imem_resp.sv
// Bench for ysyx_23060240_imem_resp: three instances (LATENCY 2, 1, 15) checked every cycle
// against a cycle-count/queue-free behavioural model, plus directed literal expectations.
module tb_ysyx_23060240_imem_resp;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_inst  [3];
`ifdef IMEM_ERR_EN
    logic        resp_err   [3];
`endif
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic [31:0] ld_data = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);
        ysyx_23060240_imem_resp #(.DEPTH(1024), .BASE(BASE), .LATENCY(LAT)) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .req_valid_i  (req_valid[gi]),
            .req_ready_o  (req_ready[gi]),
            .req_addr_i   (req_addr[gi]),
            .resp_valid_o (resp_valid[gi]),
            .resp_ready_i (resp_ready[gi]),
            .resp_inst_o  (resp_inst[gi]),
`ifdef IMEM_ERR_EN
            .resp_err_o   (resp_err[gi]),
`endif
            .ld_en_i      (ld_en),
            .ld_addr_i    (ld_addr),
            .ld_data_i    (ld_data)
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    function automatic int unsigned midx(input logic [31:0] a);
        return ((a - BASE) >> 2) % 1024;
    endfunction

    function automatic logic mfault(input logic [31:0] a);
`ifdef IMEM_ERR_EN
        return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'd4096);
`else
        return (a == 32'h0) && 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h (t=%0t)", nm, i, act, exp, $time);
        end
    endtask

    // Model: a response is due LATENCY clock edges after the accept edge, holds until taken.
    int          cyc;
    logic        m_busy [3];
    logic        m_vld  [3];
    logic        m_err  [3];
    logic [31:0] m_inst [3];
    logic [31:0] m_addr [3];
    int          m_acc  [3];
    logic [31:0] mmem   [1024];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0;
            for (int i = 0; i < 3; i++) begin
                m_busy[i] <= 1'b0;
                m_vld[i]  <= 1'b0;
                m_err[i]  <= 1'b0;
                m_inst[i] <= 32'h0;
                m_addr[i] <= 32'h0;
                m_acc[i]  <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 3; i++) begin
                if (m_vld[i] && resp_ready[i]) begin
                    m_vld[i]  <= 1'b0;
                    m_busy[i] <= 1'b0;
                end else if (m_busy[i] && !m_vld[i] && cyc == m_acc[i] + lat_of(i)) begin
                    m_vld[i]  <= 1'b1;
                    m_err[i]  <= mfault(m_addr[i]);
                    m_inst[i] <= mfault(m_addr[i]) ? 32'h0 : mmem[midx(m_addr[i])];
                end else if (!m_busy[i] && req_valid[i]) begin
                    m_busy[i] <= 1'b1;
                    m_acc[i]  <= cyc;
                    m_addr[i] <= req_addr[i];
                end
            end
            if (ld_en && !mfault(ld_addr)) mmem[midx(ld_addr)] <= ld_data;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                chk("req_ready", i, 32'(req_ready[i]), 32'(!m_busy[i]));
                chk("resp_valid", i, 32'(resp_valid[i]), 32'(m_vld[i]));
                chk("resp_inst", i, resp_inst[i], m_inst[i]);
`ifdef IMEM_ERR_EN
                chk("resp_err", i, 32'(resp_err[i]), 32'(m_err[i]));
`endif
            end
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // ldk: drive a load of ldd to the fetched address on the ldk-th edge after accept (0 = none).
    task automatic fetch(input int i, input logic [31:0] a, input int stall, input int ldk,
                         input logic [31:0] ldd, output logic [31:0] data, output logic err,
                         output int lat);
        int n;
        n = 0;
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_addr[i]  = ~a;
        while (!resp_valid[i] && n < 40) begin
            if (n + 1 == ldk) begin
                ld_en = 1'b1; ld_addr = a; ld_data = ldd;
            end
            @(posedge clk); #1;
            ld_en = 1'b0;
            n++;
        end
        lat = n;
        if (n >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout[%0d]: got no resp_valid, expected one within 40 cycles", i);
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        data = resp_inst[i];
`ifdef IMEM_ERR_EN
        err = resp_err[i];
`else
        err = 1'b0;
`endif
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
    endtask

    logic [31:0] data;
    logic        err;
    int          lat;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = 32'h0; resp_ready[i] = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
            chk("rst_resp_valid", i, 32'(resp_valid[i]), 32'd0);
            chk("rst_resp_inst", i, resp_inst[i], 32'h0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        load(32'h8000_0000, 32'h0010_0093);
        load(32'h8000_000C, 32'hAAAA_AAAA);
        load(32'h8000_0010, 32'h1234_5678);

        fetch(0, 32'h8000_0000, 0, 0, 32'h0, data, err, lat);
        chk("basic_lat", 0, 32'(lat), 32'd2);
        chk("basic_data", 0, data, 32'h0010_0093);
        chk("basic_ready_after", 0, 32'(req_ready[0]), 32'd1);

        fetch(0, 32'h8000_0010, 5, 0, 32'h0, data, err, lat);
        chk("stall_data", 0, data, 32'h1234_5678);
        chk("stall_ready_after", 0, 32'(req_ready[0]), 32'd1);

        fetch(0, 32'h8000_000C, 0, 2, 32'hBBBB_BBBB, data, err, lat);
        chk("collide_entry", 0, data, 32'hAAAA_AAAA);
        load(32'h8000_000C, 32'hAAAA_AAAA);
        fetch(0, 32'h8000_000C, 0, 1, 32'hBBBB_BBBB, data, err, lat);
        chk("collide_wait", 0, data, 32'hBBBB_BBBB);

        fetch(1, 32'h8000_0000, 0, 0, 32'h0, data, err, lat);
        chk("lat1_lat", 1, 32'(lat), 32'd1);
        chk("lat1_data", 1, data, 32'h0010_0093);
        fetch(2, 32'h8000_000C, 2, 0, 32'h0, data, err, lat);
        chk("lat15_lat", 2, 32'(lat), 32'd15);
        chk("lat15_data", 2, data, 32'hBBBB_BBBB);

`ifdef IMEM_ERR_EN
        fetch(0, 32'h8000_0002, 0, 0, 32'h0, data, err, lat);
        chk("misalign_err", 0, 32'(err), 32'd1);
        chk("misalign_inst", 0, data, 32'h0);
        fetch(0, 32'h8000_1000, 0, 0, 32'h0, data, err, lat);
        chk("range_err", 0, 32'(err), 32'd1);
        chk("range_inst", 0, data, 32'h0);
`else
        fetch(0, 32'h8000_1000, 0, 0, 32'h0, data, err, lat);
        chk("wrap_data", 0, data, 32'h0010_0093);
        fetch(0, 32'h8000_0012, 0, 0, 32'h0, data, err, lat);
        chk("align_down_data", 0, data, 32'h1234_5678);
`endif

        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8000_0010;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", 0, 32'(resp_valid[0]), 32'd0);
        chk("midrst_req_ready", 0, 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("no_stale_resp", 0, 32'(resp_valid[0]), 32'd0);
        end
        fetch(0, 32'h8000_0000, 0, 0, 32'h0, data, err, lat);
        chk("post_rst_lat", 0, 32'(lat), 32'd2);
        chk("post_rst_data", 0, data, 32'h0010_0093);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
